// File: rtl/mux_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_seq_pkg                                                      |
// | Shared state encoding and parameter defaults for mux_sequencer.  |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package mux_seq_pkg;

   // Sequencer states: idle/direct-select and scan-in-progress
   typedef enum logic {
      OCIOSO = 1'b0,
      VARRE  = 1'b1
   } state_t;

   localparam int WIDTH_DEF = 16;
   localparam int N_DEF     = 5;

endpackage : mux_seq_pkg
`default_nettype wire

// File: rtl/mux_sequencer_mux_n_to_one.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_n_to_one                                                     |
// | Combinational WIDTH-bit N-to-1 selector. Selects outside 0..N-1  |
// | return zero and raise out_of_range (correct for any N, not only  |
// | powers of two).                                                  |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module mux_n_to_one #(
   parameter int WIDTH = 16,
   parameter int N     = 5,
   parameter int SELW  = $clog2(N)
) (
   input  logic [SELW-1:0]    sel,
   input  logic [N*WIDTH-1:0] data,
   output logic [WIDTH-1:0]   y,
   output logic               out_of_range
);

   // Zero-extend before comparing so unused codes above N-1 are caught
   assign out_of_range = (32'(sel) >= 32'(N));

   // Walk the legal indices; any unmatched select leaves the zero default
   always_comb begin
      y = '0;
      for (int k = 0; k < N; k++) begin
         if (sel == SELW'(k)) begin
            y = data[k*WIDTH +: WIDTH];
         end
      end
   end

endmodule : mux_n_to_one
`default_nettype wire

// File: rtl/mux_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_sequencer                                                    |
// | Registered N-to-1 operand mux with a direct-select mode (op) and |
// | a scan mode that emits every input in order, one per clock, and  |
// | pulses fim with the last element.                                |
// | Optional feature macro: MUX_SEQ_SNAPSHOT_EN - capture all inputs |
// | when a scan starts and emit the captured copy during the scan.   |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module mux_sequencer
   import mux_seq_pkg::*;
#(
   parameter  int WIDTH = WIDTH_DEF,
   parameter  int N     = N_DEF,
   localparam int SELW  = $clog2(N)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               modo,
   input  logic [SELW-1:0]    op,
   input  logic               iniciar,
   input  logic [N*WIDTH-1:0] entradas,
   output logic [WIDTH-1:0]   saida,
   output logic               valido,
   output logic [SELW-1:0]    indice,
   output logic               fim,
   output logic               ocupado,
   output logic               erro
);

   localparam logic [SELW-1:0] c_LAST = SELW'(N - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [WIDTH-1:0]     r_saida;
   logic [SELW-1:0]      r_indice;
   logic                 r_valido;
   logic                 r_fim;
   logic                 r_erro;

   logic [WIDTH-1:0]     w_saida_nxt;
   logic [SELW-1:0]      w_indice_nxt;
   logic                 w_valido_nxt;
   logic                 w_fim_nxt;
   logic                 w_erro_nxt;
   logic                 w_snap_load;

   logic [SELW-1:0]      w_idx_inc;
   logic [SELW-1:0]      w_sel;
   logic [N*WIDTH-1:0]   w_mux_data;
   logic [WIDTH-1:0]     w_mux_y;
   logic                 w_oor;

   assign w_idx_inc = r_indice + SELW'(1);

`ifdef MUX_SEQ_SNAPSHOT_EN
   logic [N*WIDTH-1:0]   r_snap;

   // Capture every input on the edge that accepts a scan start
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_snap <= '0;
      end else if (w_snap_load) begin
         r_snap <= entradas;
      end
   end

   // Element 0 is loaded live on the start edge (same value the snapshot takes);
   // later elements come from the frozen copy
   assign w_mux_data = (r_state == VARRE) ? r_snap : entradas;
`else
   // Without a snapshot every scan element is sampled live at its load edge
   assign w_mux_data = entradas;
`endif

   // Single shared selector: op in direct mode, next scan index otherwise
   always_comb begin
      w_sel = op;
      if (r_state == VARRE) begin
         w_sel = w_idx_inc;
      end else if (modo) begin
         w_sel = '0;
      end
   end

   mux_n_to_one #(
      .WIDTH (WIDTH),
      .N     (N),
      .SELW  (SELW)
   ) u_mux (
      .sel          (w_sel),
      .data         (w_mux_data),
      .y            (w_mux_y),
      .out_of_range (w_oor)
   );

   // Next-state and next-output decode; strobes default low, data holds
   always_comb begin
      w_state_nxt  = r_state;
      w_saida_nxt  = r_saida;
      w_indice_nxt = r_indice;
      w_valido_nxt = 1'b0;
      w_fim_nxt    = 1'b0;
      w_erro_nxt   = 1'b0;
      w_snap_load  = 1'b0;
      case (r_state)
         OCIOSO: begin
            if (!modo) begin
               if (w_oor) begin
                  w_saida_nxt = '0;
                  w_erro_nxt  = 1'b1;
               end else begin
                  w_saida_nxt  = w_mux_y;
                  w_indice_nxt = op;
                  w_valido_nxt = 1'b1;
               end
            end else if (iniciar) begin
               w_saida_nxt  = w_mux_y;
               w_indice_nxt = '0;
               w_valido_nxt = 1'b1;
               w_snap_load  = 1'b1;
               w_state_nxt  = VARRE;
            end
         end
         VARRE: begin
            w_saida_nxt  = w_mux_y;
            w_indice_nxt = w_idx_inc;
            w_valido_nxt = 1'b1;
            if (w_idx_inc == c_LAST) begin
               w_fim_nxt   = 1'b1;
               w_state_nxt = OCIOSO;
            end
         end
         default: begin
            w_state_nxt = OCIOSO;
         end
      endcase
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= OCIOSO;
         r_saida  <= '0;
         r_indice <= '0;
         r_valido <= 1'b0;
         r_fim    <= 1'b0;
         r_erro   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_saida  <= w_saida_nxt;
         r_indice <= w_indice_nxt;
         r_valido <= w_valido_nxt;
         r_fim    <= w_fim_nxt;
         r_erro   <= w_erro_nxt;
      end
   end

   assign saida   = r_saida;
   assign indice  = r_indice;
   assign valido  = r_valido;
   assign fim     = r_fim;
   assign erro    = r_erro;
   assign ocupado = (r_state == VARRE);

endmodule : mux_sequencer
`default_nettype wire

// File: tb/tb_mux_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mux_sequencer                                                 |
// | Self-checking bench for mux_sequencer (WIDTH=16, N=5) against an |
// | integer-level behavioural model of direct select and scanning.   |
// | Honours MUX_SEQ_SNAPSHOT_EN in the model when it is defined.     |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_mux_sequencer;

   localparam int WIDTH = 16;
   localparam int N     = 5;
   localparam int SELW  = $clog2(N);

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               modo = 1'b0;
   logic [SELW-1:0]    op = '0;
   logic               iniciar = 1'b0;
   logic [N*WIDTH-1:0] entradas;
   logic [WIDTH-1:0]   saida;
   logic               valido;
   logic [SELW-1:0]    indice;
   logic               fim;
   logic               ocupado;
   logic               erro;

   logic [WIDTH-1:0]   ent [N];

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int               scan_pos = -1;   // index of last emitted element, -1 when idle
   logic [WIDTH-1:0] snap [N];
   logic [WIDTH-1:0] exp_saida;
   int               exp_indice;
   logic             exp_valido, exp_fim, exp_ocupado, exp_erro;

   for (genvar k = 0; k < N; k++) begin : g_pack
      assign entradas[k*WIDTH +: WIDTH] = ent[k];
   end

   always #5 clock = ~clock;

   mux_sequencer dut (
      .clock    (clock),
      .reset    (reset),
      .modo     (modo),
      .op       (op),
      .iniciar  (iniciar),
      .entradas (entradas),
      .saida    (saida),
      .valido   (valido),
      .indice   (indice),
      .fim      (fim),
      .ocupado  (ocupado),
      .erro     (erro)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".saida"},   32'(saida),   32'(exp_saida));
      check({tag, ".valido"},  32'(valido),  32'(exp_valido));
      check({tag, ".indice"},  32'(indice),  32'(exp_indice));
      check({tag, ".fim"},     32'(fim),     32'(exp_fim));
      check({tag, ".ocupado"}, 32'(ocupado), 32'(exp_ocupado));
      check({tag, ".erro"},    32'(erro),    32'(exp_erro));
   endtask

   task automatic model_reset();
      scan_pos    = -1;
      exp_saida   = '0;
      exp_indice  = 0;
      exp_valido  = 1'b0;
      exp_fim     = 1'b0;
      exp_ocupado = 1'b0;
      exp_erro    = 1'b0;
   endtask

   // One clock edge of the sequencer, expressed as "which element comes next"
   task automatic model_step();
      int pos;
      exp_fim  = 1'b0;
      exp_erro = 1'b0;
      if (scan_pos >= 0) begin
         pos = scan_pos + 1;
`ifdef MUX_SEQ_SNAPSHOT_EN
         exp_saida = snap[pos];
`else
         exp_saida = ent[pos];
`endif
         exp_indice = pos;
         exp_valido = 1'b1;
         exp_fim    = (pos == N - 1);
         scan_pos   = exp_fim ? -1 : pos;
      end else if (!modo) begin
         if (int'(op) < N) begin
            exp_saida  = ent[op];
            exp_indice = int'(op);
            exp_valido = 1'b1;
         end else begin
            exp_saida  = '0;
            exp_valido = 1'b0;
            exp_erro   = 1'b1;
         end
      end else if (iniciar) begin
         for (int k = 0; k < N; k++) snap[k] = ent[k];
         exp_saida  = ent[0];
         exp_indice = 0;
         exp_valido = 1'b1;
         scan_pos   = 0;
      end else begin
         exp_valido = 1'b0;
      end
      exp_ocupado = (scan_pos >= 0);
   endtask

   task automatic do_cycle(input logic m, input int o, input logic ini, input string tag);
      modo    = m;
      op      = SELW'(o);
      iniciar = ini;
      model_step();
      @(posedge clock);
      #1;
      check_all(tag);
   endtask

   task automatic set_inputs(input int base);
      for (int k = 0; k < N; k++) ent[k] = WIDTH'(base + k);
   endtask

   initial begin
      set_inputs(1);
      model_reset();
      #2;
      check_all("reset");
      #2 reset = 1'b0;

      // Direct sweep
      for (int i = 0; i < N; i++) do_cycle(1'b0, i, 1'b0, "direct");
      check("direct_last_value", 32'(saida), 32'd5);

      // Out of range then recovery
      do_cycle(1'b0, 5, 1'b0, "oor5");
      do_cycle(1'b0, 7, 1'b1, "oor7");
      do_cycle(1'b0, 3, 1'b0, "recover");
      check("recover_value", 32'(saida), 32'd4);

      // Scan mode idle then single scan
      do_cycle(1'b1, 0, 1'b0, "scan_idle");
      do_cycle(1'b1, 0, 1'b1, "scan_start");
      for (int i = 1; i < N; i++) do_cycle(1'b1, 0, 1'b0, "scan");
      check("scan_fim_last", 32'(fim), 32'd1);
      do_cycle(1'b1, 0, 1'b0, "scan_after");

      // Back-to-back scans, iniciar held and then wiggled during VARRE
      for (int i = 0; i < 2 * N; i++) do_cycle(1'b1, 0, 1'b1, "b2b_hold");
      for (int i = 0; i < 2 * N; i++)
         do_cycle(1'(i % 2), i % 8, 1'(i == 0 || i == N), "b2b_wiggle");

      // Mid-scan input change after element 1
      do_cycle(1'b1, 0, 1'b0, "mid_idle");
      do_cycle(1'b1, 0, 1'b1, "mid_start");
      do_cycle(1'b1, 0, 1'b0, "mid_e1");
      set_inputs(11);
      do_cycle(1'b1, 0, 1'b0, "mid_e2");
`ifdef MUX_SEQ_SNAPSHOT_EN
      check("mid_e2_value", 32'(saida), 32'd3);
`else
      check("mid_e2_value", 32'(saida), 32'd13);
`endif
      do_cycle(1'b1, 0, 1'b0, "mid_e3");
      do_cycle(1'b1, 0, 1'b0, "mid_e4");
      set_inputs(1);

      // Reset mid-scan, then restart at element 0
      do_cycle(1'b1, 0, 1'b1, "rst_start");
      do_cycle(1'b1, 0, 1'b0, "rst_e1");
      do_cycle(1'b1, 0, 1'b0, "rst_e2");
      reset = 1'b1;
      #1;
      model_reset();
      check_all("rst_async");
      #2 reset = 1'b0;
      do_cycle(1'b1, 0, 1'b1, "rst_restart");
      check("rst_restart_value", 32'(saida), 32'd1);
      for (int i = 1; i < N; i++) do_cycle(1'b1, 0, 1'b0, "rst_rescan");

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0)
            for (int k = 0; k < N; k++) ent[k] = WIDTH'($urandom);
         do_cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mux_sequencer
`default_nettype wire

// File: doc/mux_sequencer.md
# mux_sequencer

Parametrised, registered N-to-1 multiplexer for the multiplier datapath. It generalises the fixed five-input combinational operand mux to WIDTH bits and N inputs. It adds a scan mode that walks all inputs automatically, one per clock, and signals the last element. The block sits between the partial-product/operand registers and the accumulator, so the accumulator can either pick one operand by opcode or consume all operands in sequence.

## Interface
- WIDTH, 16, data width of each input and of saida
- N, 5, number of inputs (N ≥ 2)
- SELW, $clog2(N), width of op and indice (derived, not overridden)
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- modo  input  1  0 = direct select, 1 = scan
- op  input  SELW  input index in direct mode
- iniciar  input  1  scan start request (scan mode only)
- entradas  input  N*WIDTH  flattened inputs; input k = entradas[k*WIDTH +: WIDTH]
- saida  output  WIDTH  registered selected value
- valido  output  1  saida holds a new value this cycle
- indice  output  SELW  index of the value currently on saida
- fim  output  1  one-cycle pulse with the last scan element
- ocupado  output  1  scan in progress (state VARRE)
- erro  output  1  direct-mode op ≥ N on the last edge

## Operation
- Reset values: saida=0, valido=0, indice=0, fim=0, ocupado=0, erro=0, state=OCIOSO.
- States: OCIOSO, VARRE.
- OCIOSO, modo=0 (direct):
  - If op < N, each edge loads saida ← input[op], indice ← op, valido=1, erro=0.
  - If op ≥ N, the edge loads saida ← 0, valido=0, erro=1.
  - iniciar is ignored.
- OCIOSO, modo=1, iniciar=0: valido=0, fim=0, erro=0; saida and indice hold.
- OCIOSO, modo=1, iniciar=1:
  - The edge loads saida ← input[0], indice ← 0, valido=1.
  - Next state is VARRE, or stays OCIOSO with fim=1 if N=1 (N=1 is not allowed by the N ≥ 2 rule).
- VARRE:
  - Each edge loads saida ← input[indice+1], indice ← indice+1, valido=1.
  - When the new indice equals N-1: fim=1 and the next state is OCIOSO.
- In VARRE, modo, op and iniciar are ignored. The scan always completes N elements.
- Boundary cases:
  - No wrap-around: indice never exceeds N-1.
  - iniciar asserted on the first cycle back in OCIOSO (the cycle with fim=1) starts a new scan with zero gap.
  - Reset asserted mid-scan aborts the scan and returns all outputs to reset values asynchronously.
- All arithmetic on indice is unsigned SELW-bit. The op ≥ N comparison must be correct for non-power-of-two N.

## Timing
- Direct mode latency is 1 cycle: op and entradas are sampled at edge t, and saida is valid after edge t.
- Scan (iniciar sampled at edge t): element k appears after edge t+k for k = 0..N-1. fim and valido are high after edge t+N-1.
- ocupado is high after edges t .. t+N-2 and low after edge t+N-1.
- Without snapshot, scan inputs are sampled live at the edge that loads each element.
- Throughput is one element per cycle. There is no ready/backpressure; the consumer must accept every valido cycle.

## Configuration
- MUX_SEQ_SNAPSHOT_EN defined:
  - At the edge that accepts iniciar, all N inputs are captured into an internal N*WIDTH snapshot register.
  - The scan emits the snapshot, so changes on entradas during VARRE have no effect.
  - Direct mode always uses live entradas.
- Not defined: no snapshot storage; scan elements come from live entradas as described in Timing.

## Structure
- Shared package mux_seq_pkg holds:
  - the state encoding (OCIOSO=1'b0, VARRE=1'b1);
  - the defaults WIDTH_DEF=16 and N_DEF=5.
- One natural sub-module: mux_n_to_one, a purely combinational parametrised WIDTH/N selector with an out-of-range flag.
  - It is instantiated once.
  - Its select input is op in direct mode and the next index in scan mode.
- The top level holds the FSM, indice counter, output registers and the optional snapshot.

## Test plan
All scenarios use WIDTH=16, N=5, inputs 1,2,3,4,5.
- Direct sweep: modo=0, op=0..4 on consecutive cycles -> saida=1,2,3,4,5 one cycle later; valido=1, erro=0.
- Out of range: modo=0, op=5, then op=7 -> saida=0, valido=0, erro=1; op=3 next -> saida=4, erro=0.
- Scan: modo=1, iniciar pulsed at edge t -> saida=1..5 after edges t..t+4; indice=0..4; fim only after t+4; ocupado low after t+4.
- Back-to-back: iniciar held high -> two scans with no gap; fim pulses every 5 cycles; iniciar changes during VARRE have no effect.
- Mid-scan input change: inputs set to 11..15 after edge t+1 -> with MUX_SEQ_SNAPSHOT_EN the output is 1..5; without it the output is 1,2,13,14,15.
- Reset mid-scan: reset asserted between edges t+2 and t+3 -> outputs are zero immediately with ocupado=0; a new iniciar after release restarts at element 0.
